// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save accumulator slice.
package csa_pkg;

   typedef enum logic [1:0] {
      ACC     = 2'd0,
      RESOLVE = 2'd1,
      OUT     = 2'd2
   } csa_state_t;

   function automatic int calc_nchunk(input int acc_w, input int chunk_w);
      return acc_w / chunk_w;
   endfunction

endpackage

// File: rtl/csa_accumulator_if.sv
// Operand stream in, resolved total out; the accumulator is the slave side.
interface csa_accumulator_if #(
   parameter int WIDTH     = 16,
   parameter int ACC_WIDTH = 24,
   parameter int CNT_W     = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_WIDTH-1:0] out_data;
   logic [CNT_W-1:0]     out_count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count
   );
endinterface

// File: rtl/csa_row.sv
// Row of independent 3:2 full-adder cells; carry is returned unshifted.
module csa_row #(
   parameter int W = 24
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry
);

   for (genvar i = 0; i < W; i++) begin : g_cell
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign carry[i] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
   end

endmodule

// File: rtl/csa_accumulator.sv
// Multi-operand accumulator: carry-save compression per operand, then a
// chunked carry-propagate add resolves the redundant pair on the last operand.
module csa_accumulator
   import csa_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int ACC_WIDTH = 24,
   parameter int CPA_CHUNK = 8,
   parameter int CNT_W     = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   csa_accumulator_if.slave   bus
);

   localparam int NCHUNK = calc_nchunk(ACC_WIDTH, CPA_CHUNK);
   localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(NCHUNK - 1);

   csa_state_t           state;
   logic [ACC_WIDTH-1:0] s_reg;
   logic [ACC_WIDTH-1:0] c_reg;
   logic [ACC_WIDTH-1:0] res;
   logic [CNT_W-1:0]     cnt;
   logic [K_W-1:0]       k;
   logic                 cin;

   logic [ACC_WIDTH-1:0] operand;
   logic [ACC_WIDTH-1:0] row_sum;
   logic [ACC_WIDTH-1:0] row_carry;
   logic [CPA_CHUNK:0]   chunk_sum;

   assign operand = ACC_WIDTH'(bus.in_data);

   csa_row #(.W(ACC_WIDTH)) u_row (
      .a     (s_reg),
      .b     (c_reg),
      .c     (operand),
      .sum   (row_sum),
      .carry (row_carry)
   );

   // One chunk of the final carry-propagate add; the top carry feeds the next chunk.
   assign chunk_sum = {1'b0, s_reg[k*CPA_CHUNK +: CPA_CHUNK]}
                    + {1'b0, c_reg[k*CPA_CHUNK +: CPA_CHUNK]}
                    + {{CPA_CHUNK{1'b0}}, cin};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACC;
         s_reg <= '0;
         c_reg <= '0;
         res   <= '0;
         cnt   <= '0;
         k     <= '0;
         cin   <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (bus.in_valid) begin
                  s_reg <= row_sum;
                  c_reg <= row_carry << 1;
                  if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
                  if (bus.in_last) begin
                     state <= RESOLVE;
                     k     <= '0;
                     cin   <= 1'b0;
                  end
               end
            end
            RESOLVE: begin
               res[k*CPA_CHUNK +: CPA_CHUNK] <= chunk_sum[CPA_CHUNK-1:0];
               cin <= chunk_sum[CPA_CHUNK];
               if (k == K_LAST) begin
                  state <= OUT;
                  k     <= '0;
               end else begin
                  k <= k + 1'b1;
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  s_reg <= '0;
                  c_reg <= '0;
                  cnt   <= '0;
                  state <= ACC;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

   // Handshake outputs decode from state only, keeping in_* and out_ready off the output paths.
   assign bus.in_ready  = (state == ACC);
   assign bus.out_valid = (state == OUT);
   assign bus.out_data  = res;
   assign bus.out_count = cnt;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed self-checking bench for csa_accumulator (24-bit total, 3 chunks).
module tb_csa_accumulator;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   csa_accumulator_if #(.WIDTH(16), .ACC_WIDTH(24), .CNT_W(8)) bus ();

   csa_accumulator #(
      .WIDTH(16), .ACC_WIDTH(24), .CPA_CHUNK(8), .CNT_W(8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   // Presents one operand and holds it through exactly one rising edge.
   task automatic send_op(input logic [15:0] d, input logic last);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
      checks++; if (bus.out_data !== 24'h0) begin errors++; $display("[TB] FAIL reset_out_data got %h want 000000", bus.out_data); end
      checks++; if (bus.out_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_out_count got %0d want 0", bus.out_count); end
   endtask

   task automatic test_basic();
      int n;
      send_op(16'd3, 1'b0);
      send_op(16'd5, 1'b0);
      send_op(16'd7, 1'b1);
      wait_out(n);
      checks++; if (n != 3) begin errors++; $display("[TB] FAIL basic_latency got %0d edges want 3", n); end
      checks++; if (bus.out_data !== 24'h00000F) begin errors++; $display("[TB] FAIL basic_data got %h want 00000f", bus.out_data); end
      checks++; if (bus.out_count !== 8'd3) begin errors++; $display("[TB] FAIL basic_count got %0d want 3", bus.out_count); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_in_ready_out got %b want 0", bus.in_ready); end
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain got %b want 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_back got %b want 1", bus.in_ready); end
   endtask

   task automatic test_chunk_carry();
      int n;
      send_op(16'h00FF, 1'b0);
      send_op(16'h0001, 1'b1);
      wait_out(n);
      checks++; if (n != 3) begin errors++; $display("[TB] FAIL carry_latency got %0d edges want 3", n); end
      checks++; if (bus.out_data !== 24'h000100) begin errors++; $display("[TB] FAIL carry_data got %h want 000100", bus.out_data); end
      checks++; if (bus.out_count !== 8'd2) begin errors++; $display("[TB] FAIL carry_count got %0d want 2", bus.out_count); end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      int n;
      send_op(16'h1234, 1'b1);
      wait_out(n);
      checks++; if (n != 3) begin errors++; $display("[TB] FAIL single_latency got %0d edges want 3", n); end
      checks++; if (bus.out_data !== 24'h001234) begin errors++; $display("[TB] FAIL single_data got %h want 001234", bus.out_data); end
      checks++; if (bus.out_count !== 8'd1) begin errors++; $display("[TB] FAIL single_count got %0d want 1", bus.out_count); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int n;
      for (int i = 0; i < 300; i++) send_op(16'hFFFF, (i == 299));
      wait_out(n);
      checks++; if (n != 3) begin errors++; $display("[TB] FAIL b2b_latency got %0d edges want 3", n); end
      checks++; if (bus.out_data !== 24'h2BFED4) begin errors++; $display("[TB] FAIL b2b_data got %h want 2bfed4", bus.out_data); end
      checks++; if (bus.out_count !== 8'd255) begin errors++; $display("[TB] FAIL b2b_count got %0d want 255", bus.out_count); end
      @(posedge clk); #1;
   endtask

   task automatic test_hold();
      int n;
      bus.out_ready = 1'b0;
      send_op(16'h0100, 1'b0);
      send_op(16'h0200, 1'b1);
      wait_out(n);
      checks++; if (n != 3) begin errors++; $display("[TB] FAIL hold_latency got %0d edges want 3", n); end
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hAAAA;
      bus.in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid[%0d] got %b want 1", i, bus.out_valid); end
         checks++; if (bus.out_data !== 24'h000300) begin errors++; $display("[TB] FAIL hold_data[%0d] got %h want 000300", i, bus.out_data); end
         checks++; if (bus.out_count !== 8'd2) begin errors++; $display("[TB] FAIL hold_count[%0d] got %0d want 2", i, bus.out_count); end
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_in_ready[%0d] got %b want 0", i, bus.in_ready); end
      end
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release got %b want 0", bus.out_valid); end
      send_op(16'd1, 1'b0);
      send_op(16'd2, 1'b1);
      wait_out(n);
      checks++; if (bus.out_data !== 24'h000003) begin errors++; $display("[TB] FAIL cleared_data got %h want 000003", bus.out_data); end
      checks++; if (bus.out_count !== 8'd2) begin errors++; $display("[TB] FAIL cleared_count got %0d want 2", bus.out_count); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_resolve();
      int n;
      send_op(16'h0055, 1'b1);
      @(posedge clk); #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pre_ready got %b want 0", bus.in_ready); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %b want 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got %b want 1", bus.in_ready); end
      checks++; if (bus.out_data !== 24'h0) begin errors++; $display("[TB] FAIL midrst_data got %h want 000000", bus.out_data); end
      checks++; if (bus.out_count !== 8'd0) begin errors++; $display("[TB] FAIL midrst_count got %0d want 0", bus.out_count); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_op(16'd9, 1'b1);
      wait_out(n);
      checks++; if (n != 3) begin errors++; $display("[TB] FAIL postrst_latency got %0d edges want 3", n); end
      checks++; if (bus.out_data !== 24'h000009) begin errors++; $display("[TB] FAIL postrst_data got %h want 000009", bus.out_data); end
      checks++; if (bus.out_count !== 8'd1) begin errors++; $display("[TB] FAIL postrst_count got %0d want 1", bus.out_count); end
      @(posedge clk); #1;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      rst_n = 1'b0;
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_basic();
      test_chunk_carry();
      test_single();
      test_back_to_back();
      test_hold();
      test_reset_mid_resolve();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
